// File: rtl/attention_softmax_row.sv
// Streaming softmax over one attention row: ROW_LEN q.k dot products of FEAT
// features each, e^x per score, then a bit-serial divide by the row sum per element.
module attention_softmax_row #(
  parameter int DATA_W  = 8,
  parameter int FEAT    = 4,
  parameter int ROW_LEN = 4,
  parameter int EX_W    = 9,
  parameter int OUT_W   = 8,
  parameter int ACC_W   = 2*DATA_W + $clog2(FEAT) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int SUM_W  = EX_W + $clog2(ROW_LEN) + 1;
  localparam int ELEM_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int FEAT_W = (FEAT > 1) ? $clog2(FEAT) : 1;
  localparam int CNT_W  = $clog2(OUT_W + 1);
  localparam logic signed [ACC_W-1:0] SCORE_MAX = 127;
  localparam logic signed [ACC_W-1:0] SCORE_MIN = -128;

  typedef enum logic [1:0] {ACCUM, EXP, DIVIDE, OUTPUT} state_t;
  typedef enum logic {PH_A, PH_B} phase_t;

  state_t                   state, state_nxt;
  phase_t                   phase;
  logic [FEAT_W-1:0]        feat_cnt;
  logic [ELEM_W-1:0]        elem;
  logic signed [DATA_W-1:0] op_a;
  logic signed [ACC_W-1:0]  acc;
  logic [SUM_W-1:0]         sum;
  logic [EX_W-1:0]          ex_buf [ROW_LEN];
  logic [SUM_W:0]           rem;
  logic [OUT_W:0]           quo;
  logic [CNT_W-1:0]         div_cnt;
  logic [OUT_W-1:0]         out_q;

  // e^x for a Q1.6 score as UQ3.6: 2^(x*log2e) with a linear 2^frac mantissa.
  function automatic logic [EX_W-1:0] ex_fn(input logic signed [7:0] s);
    logic signed [15:0] s_ext, t, ip;
    logic [15:0]        nsh;
    logic [EX_W-1:0]    mant, res;
    s_ext = {{8{s[7]}}, s};
    t     = (s_ext * 16'sd92) >>> 6;
    ip    = t >>> 6;
    nsh   = -ip;
    mant  = EX_W'(7'd64 + {1'b0, t[5:0]});
    if (ip >= 0) res = mant << ip[1:0];
    else         res = mant >> nsh;
    return res;
  endfunction

  logic                       last_feat, last_elem, div_done;
  logic [ELEM_W-1:0]          elem_inc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sh;
  logic signed [7:0]          score;
  logic [EX_W-1:0]            ex_val;
  logic                       q_bit;
  logic [SUM_W:0]             rem_sub;
  logic [OUT_W:0]             quo_nxt;

  assign last_feat = (feat_cnt == FEAT_W'(FEAT - 1));
  assign last_elem = (elem == ELEM_W'(ROW_LEN - 1));
  assign div_done  = (div_cnt == CNT_W'(OUT_W));
  assign elem_inc  = elem + ELEM_W'(1);
  assign prod      = op_a * $signed(in_data);
  assign acc_sh    = acc >>> 8;
  assign ex_val    = ex_fn(score);
  assign q_bit     = (rem >= {1'b0, sum});
  assign rem_sub   = q_bit ? (rem - {1'b0, sum}) : rem;
  assign quo_nxt   = {quo[OUT_W-1:0], q_bit};

  always_comb begin
    score = acc_sh[7:0];
    if (acc_sh > SCORE_MAX)      score = 8'h7F;
    else if (acc_sh < SCORE_MIN) score = 8'h80;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // NOTE: next state defaults to the current state so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM:  if (in_valid && phase == PH_B && last_feat) state_nxt = EXP;
      EXP:    state_nxt = last_elem ? DIVIDE : ACCUM;
      DIVIDE: if (div_done) state_nxt = OUTPUT;
      OUTPUT: if (out_ready) state_nxt = last_elem ? ACCUM : DIVIDE;
      default: state_nxt = ACCUM;
    endcase
  end

  // NOTE: the e^x buffer is storage, not control; it has no reset and is always rewritten before use.
  always_ff @(posedge clk) begin
    if (state == EXP) ex_buf[elem] <= ex_val;
  end

  // NOTE: sequential state uses non-blocking assignments throughout so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_A;
      feat_cnt <= '0;
      elem     <= '0;
      op_a     <= '0;
      acc      <= '0;
      sum      <= '0;
      rem      <= '0;
      quo      <= '0;
      div_cnt  <= '0;
      out_q    <= '0;
    end else begin
      unique case (state)
        ACCUM: if (in_valid) begin
          if (phase == PH_A) begin
            op_a  <= in_data;
            phase <= PH_B;
            if (feat_cnt == '0) acc <= '0;
          end else begin
            acc      <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            phase    <= PH_A;
            feat_cnt <= last_feat ? '0 : feat_cnt + FEAT_W'(1);
          end
        end
        EXP: begin
          sum <= sum + SUM_W'(ex_val);
          if (last_elem) begin
            // Element 0 divides first; with a one-element row it is being written now.
            elem    <= '0;
            rem     <= (ROW_LEN == 1) ? (SUM_W+1)'(ex_val) : (SUM_W+1)'(ex_buf[0]);
            quo     <= '0;
            div_cnt <= '0;
          end else begin
            elem <= elem_inc;
          end
        end
        DIVIDE: begin
          rem     <= {rem_sub[SUM_W-1:0], 1'b0};
          quo     <= quo_nxt;
          div_cnt <= div_cnt + CNT_W'(1);
          if (div_done) out_q <= quo_nxt[OUT_W] ? '1 : quo_nxt[OUT_W-1:0];
        end
        OUTPUT: if (out_ready) begin
          if (last_elem) begin
            sum  <= '0;
            elem <= '0;
          end else begin
            elem    <= elem_inc;
            rem     <= (SUM_W+1)'(ex_buf[elem_inc]);
            quo     <= '0;
            div_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUTPUT);
  assign out_last  = out_valid && last_elem;
  assign out_data  = out_q;
  assign busy      = !(state == ACCUM && elem == '0 && feat_cnt == '0 && phase == PH_A);

endmodule

// File: tb/tb_attention_softmax_row.sv
// Bench for attention_softmax_row: row vectors with precomputed probabilities,
// a scoreboard popped on each output transfer, plus stall and reset sequences.
module tb_attention_softmax_row;

  localparam int ROW = 4;
  localparam int FT  = 4;
  localparam int NB  = ROW * FT;
  localparam int NV  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  attention_softmax_row dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0][7:0]   a;
    logic [NB-1:0][7:0]   b;
    logic [ROW-1:0][15:0] exp_out;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } sb_t;

  vec_t vecs [NV];
  sb_t  sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   beat_cnt = 0;
  int   xfer_cnt = 0;
  int   last_beat_cyc = 0;
  int   got [ROW];
  int   pos = 0;
  logic stalled = 1'b0;
  logic [7:0] held_data;
  logic       held_last;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference e^x: floor((64+f) * 2^i) where i.f = floor(s*92/64) split at 64.
  function automatic int ex_model(input int s);
    int  t, i, f;
    real r;
    t = int'($floor(s * 92.0 / 64.0));
    i = int'($floor(t / 64.0));
    f = t - 64 * i;
    r = (64.0 + f) * (2.0 ** i);
    return int'($floor(r));
  endfunction

  function automatic logic [ROW-1:0][15:0] model_row(input logic [NB-1:0][7:0] a,
                                                     input logic [NB-1:0][7:0] b);
    int ex [ROW];
    int sum, acc, s, q;
    logic [ROW-1:0][15:0] r;
    sum = 0;
    for (int e = 0; e < ROW; e++) begin
      acc = 0;
      for (int f = 0; f < FT; f++)
        acc += int'($signed(a[e*FT+f])) * int'($signed(b[e*FT+f]));
      s = acc >>> 8;
      if (s > 127) s = 127;
      if (s < -128) s = -128;
      ex[e] = ex_model(s);
      sum += ex[e];
    end
    for (int e = 0; e < ROW; e++) begin
      q = (ex[e] * 256) / sum;
      if (q > 255) q = 255;
      r[e] = 16'(q);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst && in_valid && in_ready) beat_cnt++;
  end

  // Output monitor: stall stability and scoreboard pop on each transfer.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      pos = 0;
      stalled = 1'b0;
    end else if (out_valid) begin
      if (stalled) begin
        check("stall_data", out_data, held_data);
        check("stall_last", out_last, held_last);
      end
      if (out_ready) begin
        stalled = 1'b0;
        xfer_cnt++;
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
        end
        got[pos] = out_data;
        pos = out_last ? 0 : (pos + 1) % ROW;
      end else begin
        stalled   = 1'b1;
        held_data = out_data;
        held_last = out_last;
      end
    end
  end

  task automatic drive_beat(input logic [7:0] d, input int max_gap);
    int g, n;
    g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (g) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) check("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    last_beat_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_row(input int idx, input int max_gap);
    sb_t e;
    for (int k = 0; k < ROW; k++) begin
      e.data = vecs[idx].exp_out[k][7:0];
      e.last = (k == ROW - 1);
      sb.push_back(e);
    end
    for (int k = 0; k < NB; k++) begin
      drive_beat(vecs[idx].a[k], max_gap);
      drive_beat(vecs[idx].b[k], max_gap);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 2000) begin @(posedge clk); #1; n++; end
    check(name, int'(sb.size() == 0 && in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, beats0, osum;
    vecs[0] = '0;
    for (int k = 0; k < ROW; k++) vecs[0].exp_out[k] = 16'd64;
    vecs[1] = '0;
    vecs[2] = '0;
    for (int f = 0; f < FT; f++) begin
      vecs[1].a[f] = 8'h7F; vecs[1].b[f] = 8'h7F;
      vecs[2].a[f] = 8'h80; vecs[2].b[f] = 8'h7F;
    end
    // ex(127)=472, sum=664; ex(-128)=9, sum=201.
    vecs[1].exp_out = {16'd24, 16'd24, 16'd24, 16'd181};
    vecs[2].exp_out = {16'd81, 16'd81, 16'd81, 16'd11};
    for (int k = 0; k < NB; k++) begin
      vecs[3].a[k] = 8'($urandom);
      vecs[3].b[k] = 8'($urandom);
      vecs[4].a[k] = 8'($signed(6'($urandom)));
      vecs[4].b[k] = 8'($urandom);
    end
    vecs[3].exp_out = model_row(vecs[3].a, vecs[3].b);
    vecs[4].exp_out = model_row(vecs[4].a, vecs[4].b);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      send_row(i, 0);
      if (i == 0) begin
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("first_out_latency", cyc - last_beat_cyc, 10);
      end
      wait_drain("row_drain");
      if (i == 1) begin
        check("sat_pos_eq12", got[1], got[2]);
        check("sat_pos_eq23", got[2], got[3]);
      end
      if (i == 2) begin
        osum = got[0] + got[1] + got[2] + got[3];
        check("sat_neg_order", int'(got[0] < got[1]), 1);
        check("sat_neg_sum_range", int'(osum <= 256 && osum >= 256 - ROW), 1);
      end
    end

    beats0 = beat_cnt;
    send_row(0, 3);
    wait_drain("gap_drain");
    check("gap_beats", beat_cnt - beat0_fix(beats0), 2 * NB);

    out_ready = 1'b0;
    base = xfer_cnt;
    send_row(0, 0);
    for (int k = 0; k < ROW; k++) begin
      n = 0;
      while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
      repeat (5) begin @(posedge clk); #1; end
      check("stall_in_ready_low", in_ready, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    check("stall_in_ready_after", in_ready, 1);
    check("stall_xfers", xfer_cnt - base, ROW);
    out_ready = 1'b1;
    wait_drain("stall_drain");

    base = xfer_cnt;
    send_row(0, 0);
    n = 0;
    while (xfer_cnt != base + 2 && n < 200) begin @(posedge clk); #1; n++; end
    check("abort_reach_elem2", xfer_cnt - base, 2);
    repeat (3) begin @(posedge clk); #1; end
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    send_row(0, 0);
    wait_drain("abort_drain");
    for (int k = 0; k < ROW; k++) check("abort_row_clean", got[k], 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic int beat0_fix(input int b);
    return b;
  endfunction

endmodule
